// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port arbiter/sequencer sharing the data-memory port, with lock
//            support and fixed two-cycle read latency. Round-robin conflict
//            policy when DMEM_ARB_RR_EN is defined, fixed A-priority otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1000
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              A_req,
  input  logic              A_we,
  input  logic              A_lock,
  input  logic [ADDR_W-1:0] A_addr,
  input  logic [DATA_W-1:0] A_wdata,
  output logic              A_gnt,
  output logic              A_rvalid,
  output logic              A_err,
  output logic [DATA_W-1:0] A_rdata,
  input  logic              B_req,
  input  logic              B_we,
  input  logic              B_lock,
  input  logic [ADDR_W-1:0] B_addr,
  input  logic [DATA_W-1:0] B_wdata,
  output logic              B_gnt,
  output logic              B_rvalid,
  output logic              B_err,
  output logic [DATA_W-1:0] B_rdata,
  output logic              Mem_read,
  output logic              Mem_write,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Write_data,
  input  logic [DATA_W-1:0] Read_data
);

  localparam logic [ADDR_W-1:0] c_DEPTH = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t r_state;

  logic              w_a_gnt;
  logic              w_b_gnt;
  logic              w_a_wins;
  logic              w_any;
  logic              w_we;
  logic              w_oor;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // Issue stage (T+1) and response stage (T+2) registers
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_write_data;
  logic              r_s1_valid;
  logic              r_s1_b;
  logic              r_s1_we;
  logic              r_s1_err;
  logic              r_a_rvalid;
  logic              r_a_err;
  logic              r_b_rvalid;
  logic              r_b_err;
  logic              w_resp;

`ifdef DMEM_ARB_RR_EN
  logic r_last_b;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_last_b <= 1'b1;
    end else if (w_a_gnt) begin
      r_last_b <= 1'b0;
    end else if (w_b_gnt) begin
      r_last_b <= 1'b1;
    end
  end

  assign w_a_wins = r_last_b;
`else
  assign w_a_wins = 1'b1;
`endif

  // Grants are masked while reset is asserted so nothing is accepted then
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (Rst_n) begin
      case (r_state)
        IDLE: begin
          if (A_req && B_req) begin
            w_a_gnt = w_a_wins;
            w_b_gnt = !w_a_wins;
          end else begin
            w_a_gnt = A_req;
            w_b_gnt = B_req;
          end
        end
        OWN_A:   w_a_gnt = A_req;
        OWN_B:   w_b_gnt = B_req;
        default: begin
          w_a_gnt = 1'b0;
          w_b_gnt = 1'b0;
        end
      endcase
    end
  end

  assign A_gnt   = w_a_gnt;
  assign B_gnt   = w_b_gnt;
  assign w_any   = w_a_gnt || w_b_gnt;
  assign w_addr  = w_b_gnt ? B_addr  : A_addr;
  assign w_we    = w_b_gnt ? B_we    : A_we;
  assign w_wdata = w_b_gnt ? B_wdata : A_wdata;
  assign w_oor   = (w_addr >= c_DEPTH);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_a_gnt) begin
            r_state <= A_lock ? OWN_A : IDLE;
          end else if (w_b_gnt) begin
            r_state <= B_lock ? OWN_B : IDLE;
          end
        end
        OWN_A: begin
          if (w_a_gnt) begin
            r_state <= A_lock ? OWN_A : IDLE;
          end else if (!A_req && !A_lock) begin
            r_state <= IDLE;
          end
        end
        OWN_B: begin
          if (w_b_gnt) begin
            r_state <= B_lock ? OWN_B : IDLE;
          end else if (!B_req && !B_lock) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Errored requests (read or write) and in-range reads produce a response
  assign w_resp = r_s1_valid && (!r_s1_we || r_s1_err);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_address    <= '0;
      r_write_data <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_b       <= 1'b0;
      r_s1_we      <= 1'b0;
      r_s1_err     <= 1'b0;
      r_a_rvalid   <= 1'b0;
      r_a_err      <= 1'b0;
      r_b_rvalid   <= 1'b0;
      r_b_err      <= 1'b0;
    end else begin
      r_mem_read  <= w_any && !w_we && !w_oor;
      r_mem_write <= w_any &&  w_we && !w_oor;
      if (w_any && !w_oor) begin
        r_address    <= w_addr;
        r_write_data <= w_wdata;
      end
      r_s1_valid <= w_any;
      r_s1_b     <= w_b_gnt;
      r_s1_we    <= w_we;
      r_s1_err   <= w_oor;
      r_a_rvalid <= w_resp && !r_s1_b;
      r_a_err    <= w_resp && !r_s1_b && r_s1_err;
      r_b_rvalid <= w_resp &&  r_s1_b;
      r_b_err    <= w_resp &&  r_s1_b && r_s1_err;
    end
  end

  assign Mem_read   = r_mem_read;
  assign Mem_write  = r_mem_write;
  assign Address    = r_address;
  assign Write_data = r_write_data;
  assign A_rvalid   = r_a_rvalid;
  assign A_err      = r_a_err;
  assign B_rvalid   = r_b_rvalid;
  assign B_err      = r_b_err;
  assign A_rdata    = (r_a_rvalid && !r_a_err) ? Read_data : '0;
  assign B_rdata    = (r_b_rvalid && !r_b_err) ? Read_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Cycle-table bench for dmem_arbiter with a behavioural data memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        A_req, A_we, A_lock, B_req, B_we, B_lock;
  logic [31:0] A_addr, A_wdata, B_addr, B_wdata;
  logic        A_gnt, A_rvalid, A_err, B_gnt, B_rvalid, B_err;
  logic [31:0] A_rdata, B_rdata;
  logic        Mem_read, Mem_write;
  logic [31:0] Address, Write_data, Read_data;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(1000)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .A_req(A_req), .A_we(A_we), .A_lock(A_lock), .A_addr(A_addr), .A_wdata(A_wdata),
    .A_gnt(A_gnt), .A_rvalid(A_rvalid), .A_err(A_err), .A_rdata(A_rdata),
    .B_req(B_req), .B_we(B_we), .B_lock(B_lock), .B_addr(B_addr), .B_wdata(B_wdata),
    .B_gnt(B_gnt), .B_rvalid(B_rvalid), .B_err(B_err), .B_rdata(B_rdata),
    .Mem_read(Mem_read), .Mem_write(Mem_write), .Address(Address),
    .Write_data(Write_data), .Read_data(Read_data)
  );

  always #5 Clk = ~Clk;

  // Data memory: word i holds 0xA000+i, except word 5 which holds 0x1234
  logic [31:0] mem [0:1023];
  logic        mem_ready = 1'b0;
  always @(posedge Clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000 + 32'(i);
      mem[5]    <= 32'h1234;
      mem_ready <= 1'b1;
      Read_data <= 32'h0;
    end else begin
      if (Mem_write) mem[Address[9:0]] <= Write_data;
      if (Mem_read)  Read_data <= mem[Address[9:0]];
    end
  end

  typedef struct packed {
    logic        rst_n;
    logic        a_req, a_we, a_lock;
    logic [31:0] a_addr, a_wdata;
    logic        b_req, b_we, b_lock;
    logic [31:0] b_addr, b_wdata;
    logic        e_agnt, e_bgnt, e_mrd, e_mwr;
    logic [31:0] e_addr, e_wdata;
    logic        e_arv, e_aerr;
    logic [31:0] e_ard;
    logic        e_brv, e_berr;
    logic [31:0] e_brd;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t nv();
    vec_t v = '0;
    v.rst_n = 1'b1;
    return v;
  endfunction

  function automatic vec_t in_a(vec_t vi, bit we, bit lk, int addr, int wd);
    vec_t v = vi;
    v.a_req = 1'b1; v.a_we = we; v.a_lock = lk; v.a_addr = 32'(addr); v.a_wdata = 32'(wd);
    return v;
  endfunction

  function automatic vec_t in_b(vec_t vi, bit we, bit lk, int addr, int wd);
    vec_t v = vi;
    v.b_req = 1'b1; v.b_we = we; v.b_lock = lk; v.b_addr = 32'(addr); v.b_wdata = 32'(wd);
    return v;
  endfunction

  function automatic vec_t ex_g(vec_t vi, bit ag, bit bg);
    vec_t v = vi;
    v.e_agnt = ag; v.e_bgnt = bg;
    return v;
  endfunction

  function automatic vec_t ex_m(vec_t vi, bit rd, bit wr, int addr, int wd);
    vec_t v = vi;
    v.e_mrd = rd; v.e_mwr = wr; v.e_addr = 32'(addr); v.e_wdata = 32'(wd);
    return v;
  endfunction

  function automatic vec_t ex_ra(vec_t vi, bit err, int data);
    vec_t v = vi;
    v.e_arv = 1'b1; v.e_aerr = err; v.e_ard = 32'(data);
    return v;
  endfunction

  function automatic vec_t ex_rb(vec_t vi, bit err, int data);
    vec_t v = vi;
    v.e_brv = 1'b1; v.e_berr = err; v.e_brd = 32'(data);
    return v;
  endfunction

  task automatic apply(input vec_t v);
    Rst_n  = v.rst_n;
    A_req  = v.a_req;  A_we = v.a_we;  A_lock = v.a_lock; A_addr = v.a_addr; A_wdata = v.a_wdata;
    B_req  = v.b_req;  B_we = v.b_we;  B_lock = v.b_lock; B_addr = v.b_addr; B_wdata = v.b_wdata;
  endtask

  task automatic check(input string nm, input vec_t v);
    logic ok;
    ok = ({A_gnt, B_gnt, Mem_read, Mem_write} === {v.e_agnt, v.e_bgnt, v.e_mrd, v.e_mwr})
      && ({A_rvalid, A_err, A_rdata} === {v.e_arv, v.e_aerr, v.e_ard})
      && ({B_rvalid, B_err, B_rdata} === {v.e_brv, v.e_berr, v.e_brd})
      && (!(v.e_mrd || v.e_mwr) || Address === v.e_addr)
      && (!v.e_mwr || Write_data === v.e_wdata);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b%b rd=%b wr=%b addr=%0h wd=%0h a=%b%b/%0h b=%b%b/%0h, need gnt=%b%b rd=%b wr=%b addr=%0h wd=%0h a=%b%b/%0h b=%b%b/%0h",
               nm, A_gnt, B_gnt, Mem_read, Mem_write, Address, Write_data,
               A_rvalid, A_err, A_rdata, B_rvalid, B_err, B_rdata,
               v.e_agnt, v.e_bgnt, v.e_mrd, v.e_mwr, v.e_addr, v.e_wdata,
               v.e_arv, v.e_aerr, v.e_ard, v.e_brv, v.e_berr, v.e_brd);
    end
  endtask

  task automatic step(input string nm, input vec_t v);
    apply(v);
    @(negedge Clk);
    check(nm, v);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    vec_t v;
    apply(nv());
    Rst_n = 1'b0;

    // Reset state, then idle
    v = nv(); v.rst_n = 1'b0; vecs.push_back(v);
    vecs.push_back(nv());

    // Both ports request reads for four cycles: A addr 1, B addr 2
`ifdef DMEM_ARB_RR_EN
    vecs.push_back(ex_g(in_b(in_a(nv(), 0, 0, 1, 0), 0, 0, 2, 0), 1, 0));
    vecs.push_back(ex_m(ex_g(in_b(in_a(nv(), 0, 0, 1, 0), 0, 0, 2, 0), 0, 1), 1, 0, 1, 0));
    vecs.push_back(ex_ra(ex_m(ex_g(in_b(in_a(nv(), 0, 0, 1, 0), 0, 0, 2, 0), 1, 0), 1, 0, 2, 0), 0, 'hA001));
    vecs.push_back(ex_rb(ex_m(ex_g(in_b(in_a(nv(), 0, 0, 1, 0), 0, 0, 2, 0), 0, 1), 1, 0, 1, 0), 0, 'hA002));
    vecs.push_back(ex_ra(ex_m(nv(), 1, 0, 2, 0), 0, 'hA001));
    vecs.push_back(ex_rb(nv(), 0, 'hA002));
`else
    vecs.push_back(ex_g(in_b(in_a(nv(), 0, 0, 1, 0), 0, 0, 2, 0), 1, 0));
    vecs.push_back(ex_m(ex_g(in_b(in_a(nv(), 0, 0, 1, 0), 0, 0, 2, 0), 1, 0), 1, 0, 1, 0));
    vecs.push_back(ex_ra(ex_m(ex_g(in_b(in_a(nv(), 0, 0, 1, 0), 0, 0, 2, 0), 1, 0), 1, 0, 1, 0), 0, 'hA001));
    vecs.push_back(ex_ra(ex_m(ex_g(in_b(in_a(nv(), 0, 0, 1, 0), 0, 0, 2, 0), 1, 0), 1, 0, 1, 0), 0, 'hA001));
    vecs.push_back(ex_ra(ex_m(nv(), 1, 0, 1, 0), 0, 'hA001));
    vecs.push_back(ex_ra(nv(), 0, 'hA001));
`endif
    vecs.push_back(nv());

    // Single read of word 5
    vecs.push_back(ex_g(in_a(nv(), 0, 0, 5, 0), 1, 0));
    vecs.push_back(ex_m(nv(), 1, 0, 5, 0));
    vecs.push_back(ex_ra(nv(), 0, 'h1234));
    vecs.push_back(nv());

    // Out-of-range write: no strobe, error response
    vecs.push_back(ex_g(in_a(nv(), 1, 0, 1000, 'hDEAD), 1, 0));
    vecs.push_back(nv());
    vecs.push_back(ex_ra(nv(), 1, 0));
    vecs.push_back(nv());

    // A writes 0xCAFE to word 7, B reads it back the next cycle
    vecs.push_back(ex_g(in_a(nv(), 1, 0, 7, 'hCAFE), 1, 0));
    vecs.push_back(ex_m(ex_g(in_b(nv(), 0, 0, 7, 0), 0, 1), 0, 1, 7, 'hCAFE));
    vecs.push_back(ex_m(nv(), 1, 0, 7, 0));
    vecs.push_back(ex_rb(nv(), 0, 'hCAFE));
    vecs.push_back(nv());

    // B locks and reads word 3 repeatedly while A waits for word 4
    vecs.push_back(ex_g(in_b(nv(), 0, 1, 3, 0), 0, 1));
    vecs.push_back(ex_m(ex_g(in_b(in_a(nv(), 0, 0, 4, 0), 0, 1, 3, 0), 0, 1), 1, 0, 3, 0));
    vecs.push_back(ex_rb(ex_m(ex_g(in_b(in_a(nv(), 0, 0, 4, 0), 0, 1, 3, 0), 0, 1), 1, 0, 3, 0), 0, 'hA003));
    vecs.push_back(ex_rb(ex_m(ex_g(in_b(in_a(nv(), 0, 0, 4, 0), 0, 0, 3, 0), 0, 1), 1, 0, 3, 0), 0, 'hA003));
    vecs.push_back(ex_rb(ex_m(ex_g(in_a(nv(), 0, 0, 4, 0), 1, 0), 1, 0, 3, 0), 0, 'hA003));
    vecs.push_back(ex_rb(ex_m(nv(), 1, 0, 4, 0), 0, 'hA003));
    vecs.push_back(ex_ra(nv(), 0, 'hA004));
    vecs.push_back(nv());

    @(posedge Clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("row%0d", i), vecs[i]);
    end

    // Reset asserted the cycle after a read is granted, with A still requesting
    step("rst_grant", ex_g(in_a(nv(), 0, 0, 5, 0), 1, 0));
    v = in_a(nv(), 0, 0, 5, 0); v.rst_n = 1'b0;
    step("rst_low1", v);
    step("rst_low2", v);
    step("rst_regrant", ex_g(in_a(nv(), 0, 0, 5, 0), 1, 0));
    step("rst_strobe", ex_m(nv(), 1, 0, 5, 0));
    step("rst_resp", ex_ra(nv(), 0, 'h1234));
    step("rst_quiet", nv());

    // Lock released by dropping req and lock without a further grant
    step("rel_lock", ex_g(in_a(nv(), 0, 1, 8, 0), 1, 0));
    step("rel_drop", ex_m(nv(), 1, 0, 8, 0));
    step("rel_b_ok", ex_ra(ex_g(in_b(nv(), 0, 0, 9, 0), 0, 1), 0, 'hA008));
    step("rel_strobe", ex_m(nv(), 1, 0, 9, 0));
    step("rel_resp", ex_rb(nv(), 0, 'hA009));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
